// File: rtl/instr_fetch.sv
// Instruction fetch FSM: FETCH -> ISSUE -> FETCH, one instruction per 2 cycles with a zero-wait memory.
// Stalls hold the issued instruction in ISSUE; an ack timeout parks the block in HALT until reset.
module instr_fetch #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_rdata,
    input  logic       imem_ack,
    input  logic       stall,
    input  logic       pc_sel,
    output logic [7:0] instr,
    output logic [1:0] opcode,
    output logic       instr_valid,
    output logic [7:0] pc,
    output logic       fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Last no-ack cycle count before the counter would reach ACK_TIMEOUT.
    localparam logic [3:0] LP_WAIT_LAST = 4'(ACK_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] w_pc_nxt;
    logic [7:0] r_instr;
    logic [7:0] w_instr_nxt;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_nxt;
    logic       r_fetch_err;
    logic       w_fetch_err_nxt;
    logic [7:0] w_offset;

    assign w_offset = {{2{r_instr[5]}}, r_instr[5:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_instr     <= 8'h00;
            r_wait_cnt  <= 4'd0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_fetch_err <= w_fetch_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_fetch_err_nxt = r_fetch_err;
        case (r_state)
            FETCH: begin
                // An ack in the timeout cycle still takes priority over the error.
                if (imem_ack) begin
                    w_instr_nxt    = imem_rdata;
                    w_wait_cnt_nxt = 4'd0;
                    w_state_nxt    = ISSUE;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_fetch_err_nxt = 1'b1;
                    w_state_nxt     = HALT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    w_pc_nxt       = r_pc + 8'd1 + (pc_sel ? w_offset : 8'd0);
                    w_wait_cnt_nxt = 4'd0;
                    w_state_nxt    = FETCH;
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // Gating with rst_n keeps the request low for the whole reset window.
    assign imem_req    = rst_n && (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[7:6];
    assign instr_valid = (r_state == ISSUE);
    assign pc          = r_pc;
    assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected (pc, instr) pairs checked at each issue.
module tb_instr_fetch;

    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_ack;
    logic       stall;
    logic       pc_sel;
    logic [7:0] instr;
    logic [1:0] opcode;
    logic       instr_valid;
    logic [7:0] pc;
    logic       fetch_err;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] m_pc     = RESET_PC;
    logic       prev_valid = 1'b0;
    exp_t       sb[$];

    instr_fetch #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .stall      (stall),
        .pc_sel     (pc_sel),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: fetch address must track the model pc; every new issue pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (imem_req) begin
                n_checks++;
                if (imem_addr !== m_pc) $display("FAIL fetch_addr: got %h expected %h", imem_addr, m_pc);
                else n_pass++;
            end
            if (instr_valid && !prev_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL issue_unexpected: pc %h instr %h with empty scoreboard", pc, instr);
                end else begin
                    e = sb.pop_front();
                    if (pc !== e.pc || instr !== e.instr || opcode !== e.instr[7:6])
                        $display("FAIL issue: got pc %h instr %h opcode %b expected pc %h instr %h",
                                 pc, instr, opcode, e.pc, e.instr);
                    else n_pass++;
                end
            end
            prev_valid = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Stimulus only: called just after an edge that left the DUT in FETCH.
    task automatic run_instr(input logic [7:0] data, input int waits, input logic sel);
        logic [7:0] off;
        imem_ack = 1'b0;
        repeat (waits) begin @(posedge clk); #1; end
        imem_ack   = 1'b1;
        imem_rdata = data;
        sb.push_back('{pc: m_pc, instr: data});
        stall  = 1'b0;
        pc_sel = sel;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        off  = {{2{data[5]}}, data[5:0]};
        m_pc = m_pc + 8'd1 + (sel ? off : 8'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00; stall = 1'b0; pc_sel = 1'b0;
        #2;
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0)
            $display("FAIL reset_ctrl: got req %b valid %b err %b expected 0 0 0", imem_req, instr_valid, fetch_err);
        else n_pass++;
        n_checks++;
        if (pc !== RESET_PC || instr !== 8'h00 || opcode !== 2'b00)
            $display("FAIL reset_regs: got pc %h instr %h opcode %b expected %h 00 00", pc, instr, opcode, RESET_PC);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        m_pc  = RESET_PC;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
            $display("FAIL reset_first_req: got req %b addr %h expected 1 %h", imem_req, imem_addr, RESET_PC);
        else n_pass++;
        #1;
    endtask

    // Ack held high throughout: valid must pulse 0,1,0,1; the ack seen in ISSUE must not disturb instr.
    task automatic test_back_to_back();
        logic exp_v [4];
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        imem_ack = 1'b1; imem_rdata = 8'h05; pc_sel = 1'b0; stall = 1'b0;
        sb.push_back('{pc: 8'h00, instr: 8'h05});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (instr_valid !== exp_v[i]) $display("FAIL b2b_valid[%0d]: got %b expected %b", i, instr_valid, exp_v[i]);
            else n_pass++;
            @(posedge clk); #1;
            if (i == 0) begin
                imem_rdata = 8'h41;
                sb.push_back('{pc: 8'h01, instr: 8'h41});
            end
            if (i == 1) m_pc = 8'h01;
            if (i == 2) imem_ack = 1'b0;
            if (i == 3) m_pc = 8'h02;
        end
        n_checks++;
        if (imem_addr !== 8'h02) $display("FAIL b2b_next_addr: got %h expected 02", imem_addr);
        else n_pass++;
    endtask

    task automatic test_jump();
        run_instr(8'h0D, 1, 1'b1);  // 02 -> 10
        run_instr(8'h83, 0, 1'b1);
        n_checks++;
        if (imem_addr !== 8'h14) $display("FAIL jump_fwd: got %h expected 14", imem_addr);
        else n_pass++;
        run_instr(8'hBC, 0, 1'b1);  // 14 -> 11
        run_instr(8'hBE, 0, 1'b1);
        n_checks++;
        if (imem_addr !== 8'h10) $display("FAIL jump_back: got %h expected 10", imem_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_instr(8'hEE, 2, 1'b1);  // 10 -> FF
        n_checks++;
        if (imem_addr !== 8'hFF) $display("FAIL wrap_setup: got %h expected FF", imem_addr);
        else n_pass++;
        run_instr(8'h40, 0, 1'b0);
        n_checks++;
        if (imem_addr !== 8'h00) $display("FAIL wrap_inc: got %h expected 00", imem_addr);
        else n_pass++;
        run_instr(8'hC0, 0, 1'b0);
        run_instr(8'hBC, 0, 1'b1);
        n_checks++;
        if (imem_addr !== 8'hFE) $display("FAIL wrap_neg: got %h expected FE", imem_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        imem_ack = 1'b1; imem_rdata = 8'hA7; pc_sel = 1'b0; stall = 1'b1;
        sb.push_back('{pc: 8'hFE, instr: 8'hA7});
        @(posedge clk); #1;
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = (i == 1);
            imem_rdata = 8'h3C;
            @(negedge clk);
            n_checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 8'hA7 || pc !== 8'hFE)
                $display("FAIL stall_hold[%0d]: got valid %b req %b instr %h pc %h expected 1 0 A7 FE",
                         i, instr_valid, imem_req, instr, pc);
            else n_pass++;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        m_pc = 8'hFF;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'hFF)
            $display("FAIL stall_release: got req %b addr %h expected 1 FF", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_ack_at_limit();
        run_instr(8'h6A, 14, 1'b0);  // ack on the 15th FETCH cycle
        n_checks++;
        if (fetch_err !== 1'b0 || imem_addr !== 8'h00)
            $display("FAIL ack_at_limit: got err %b addr %h expected 0 00", fetch_err, imem_addr);
        else n_pass++;
    endtask

    task automatic test_timeout();
        imem_ack = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        n_checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL timeout_early: got err %b req %b expected 0 1", fetch_err, imem_req);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00)
            $display("FAIL timeout_halt: got err %b req %b valid %b pc %h expected 1 0 0 00",
                     fetch_err, imem_req, instr_valid, pc);
        else n_pass++;
        imem_ack = 1'b1; imem_rdata = 8'h55;
        repeat (3) begin @(posedge clk); #1; end
        imem_ack = 1'b0;
        n_checks++;
        if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || instr !== 8'h6A || imem_req !== 1'b0)
            $display("FAIL halt_late_ack: got err %b valid %b instr %h req %b expected 1 0 6A 0",
                     fetch_err, instr_valid, instr, imem_req);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b0 || pc !== RESET_PC)
            $display("FAIL areset_halt: got err %b req %b pc %h expected 0 0 %h", fetch_err, imem_req, pc, RESET_PC);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1; m_pc = RESET_PC;
        run_instr(8'h07, 0, 1'b1);  // 00 -> 08
        imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || pc !== RESET_PC || instr !== 8'h00)
            $display("FAIL areset_fetch: got req %b valid %b err %b pc %h instr %h expected 0 0 0 %h 00",
                     imem_req, instr_valid, fetch_err, pc, instr, RESET_PC);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1; m_pc = RESET_PC;
        run_instr(8'h81, 1, 1'b0);
        n_checks++;
        if (imem_addr !== 8'h01 || fetch_err !== 1'b0)
            $display("FAIL areset_recover: got addr %h err %b expected 01 0", imem_addr, fetch_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_jump();
        test_wrap();
        test_stall();
        test_ack_at_limit();
        test_timeout();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter ACK_TIMEOUT, default 15: maximum wait cycles for imem_ack before a fetch error is flagged.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  8  instruction memory read address.
REQ-007 imem_rdata  input  8  instruction byte; valid when imem_ack=1.
REQ-008 imem_ack  input  1  memory read-complete strobe.
REQ-009 stall  input  1  downstream hold request; freezes the issued instruction.
REQ-010 pc_sel  input  1  jump select from the control unit, evaluated against the issued instruction.
REQ-011 instr  output  8  instruction register: opcode [7:6], signed jump offset [5:0].
REQ-012 opcode  output  2  instr[7:6], fed to the control unit.
REQ-013 instr_valid  output  1  instr holds a live instruction for decode/execute.
REQ-014 pc  output  8  address of the instruction currently in instr.
REQ-015 fetch_err  output  1  sticky flag: ACK_TIMEOUT exceeded.

Function
REQ-016 FSM states SHALL be FETCH, ISSUE, HALT.
REQ-017 FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
- On imem_ack=1, latch imem_rdata into instr and go to ISSUE on the next edge.
REQ-018 imem_addr SHALL hold stable while imem_req=1; it SHALL change only after an ack has been taken.
REQ-019 FETCH wait counter: 4 bits, cleared on entry to FETCH, increments each cycle without ack.
- When the counter reaches ACK_TIMEOUT with no ack: set fetch_err=1 and go to HALT.
- An ack arriving in the same cycle the counter reaches ACK_TIMEOUT wins: normal latch, no error.
REQ-020 ISSUE: instr_valid=1, imem_req=0; instr and pc held constant.
REQ-021 ISSUE with stall=1: remain in ISSUE with all outputs unchanged.
REQ-022 ISSUE with stall=0: on the next edge, update pc and return to FETCH.
- pc_sel=0: pc <= pc+1.
- pc_sel=1: pc <= pc + 1 + sign_extend(instr[5:0]).
REQ-023 PC arithmetic SHALL be 8-bit modulo 256 in both directions: 8'hFF+1 -> 8'h00; 8'h02+1+(-4) -> 8'hFF.
REQ-024 imem_ack while not in FETCH SHALL be ignored; instr is not modified.
REQ-025 HALT: imem_req=0, instr_valid=0, pc frozen, fetch_err=1.
- HALT is exited only by reset.
REQ-026 Minimum issue rate with a zero-wait memory (ack in the first FETCH cycle) SHALL be one instruction per 2 cycles.
REQ-027 opcode SHALL equal instr[7:6] at all times, including outside ISSUE.

Reset
REQ-028 On rst_n=0, asynchronously and regardless of state or mid-fetch activity, the block SHALL force:
- state=FETCH, pc=RESET_PC, instr=8'h00;
- instr_valid=0, fetch_err=0, wait counter=0.
REQ-029 imem_req SHALL be 0 while rst_n=0.
- The first request is asserted in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.

Verification
REQ-030 Reset release, memory acks each FETCH with bytes 8'h05, 8'h41 -> imem_addr 00 then 01; instr_valid pulses every second cycle; pc 00 then 01.
REQ-031 pc=8'h10, instr=8'h83 with pc_sel=1 -> next imem_addr=8'h14; instr=8'hBE (offset -2) with pc_sel=1 -> next imem_addr=8'h10.
REQ-032 pc=8'hFF, pc_sel=0 -> next fetch address 8'h00; pc=8'h01, instr=8'hBC (offset -4), pc_sel=1 -> next fetch address 8'hFE.
REQ-033 stall=1 for 3 cycles during ISSUE -> instr, pc and instr_valid=1 held for all 3 cycles; no imem_req; stray imem_ack ignored.
REQ-034 Ack withheld for 15 cycles -> fetch_err=1, imem_req=0, FSM in HALT; a later ack has no effect. Ack on cycle 15 exactly -> normal issue, fetch_err=0.
REQ-035 rst_n pulsed low mid-FETCH with imem_req=1 -> imem_req, instr_valid and fetch_err drop immediately, without waiting for a clock edge; pc=RESET_PC.
